// File: rtl/score_digit_bitmap_if.sv
// score_digit_bitmap_if: bracket-to-digit pixel bus (offsets, request, digit, frame pulse) and the drawing outputs.
interface score_digit_bitmap_if;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic [3:0]  digit;
    logic        startOfFrame;
    logic        drawingRequest;
    logic [7:0]  RGBout;

    modport master (
        output offsetX, offsetY, InsideRectangle, digit, startOfFrame,
        input  drawingRequest, RGBout
    );

    modport slave (
        input  offsetX, offsetY, InsideRectangle, digit, startOfFrame,
        output drawingRequest, RGBout
    );
endinterface

// File: rtl/score_digit_bitmap.sv
// score_digit_bitmap: draws an 8x16 font digit scaled x2 in a 16x32 bracket, blinking for a while after each change.
module score_digit_bitmap #(
    parameter logic [7:0]  DIGIT_COLOR  = 8'h5b,
    parameter int unsigned BLINK_FRAMES = 60,
    parameter int unsigned BLINK_PERIOD = 8
) (
    input logic                 clk_i,
    input logic                 resetN_i,
    score_digit_bitmap_if.slave bus
);
    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
    localparam logic [7:0] FRAMES = 8'(BLINK_FRAMES);
    localparam logic [7:0] PERIOD = 8'(BLINK_PERIOD);
    // Row 0 is the top byte, MSB is the leftmost column; codes 10..15 are blank.
    localparam logic [127:0] FONT [16] = '{
        128'h00003C66_66666666_66666666_3C000000,
        128'h00001838_78181818_18181818_7E000000,
        128'h00003C66_06060C18_30606066_7E000000,
        128'h00003C66_06061C06_06060666_3C000000,
        128'h00000C1C_3C6CCCCC_FE0C0C0C_1E000000,
        128'h00007E60_60607C06_06060666_3C000000,
        128'h00001C30_60607C66_66666666_3C000000,
        128'h00007E66_06060C18_18181818_18000000,
        128'h00003C66_66663C66_66666666_3C000000,
        128'h00003C66_6666663E_0606060C_38000000,
        128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0
    };

    typedef enum logic {IDLE, BLINK} state_t;

    state_t      state_q, state_d;
    logic        visible_q, visible_d;
    logic [7:0]  frame_q, frame_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  prev_q;
    logic        draw_q, draw_d;
    logic [7:0]  rgb_q;
    logic [127:0] glyph;
    logic        font_bit;
    logic        in_range;
    logic        change;
    logic [7:0]  frame_dec;
    logic [7:0]  phase_dec;

    // Bit index 127-(8*row+col) is simply the inverted {row,col}.
    always_comb begin
        glyph    = FONT[bus.digit];
        font_bit = glyph[~{bus.offsetY[4:1], bus.offsetX[3:1]}];
        in_range = bus.offsetX < 11'd16 && bus.offsetY < 11'd32;
        draw_d   = bus.InsideRectangle && bus.digit <= 4'd9 && in_range && font_bit && visible_q;
    end

    always_comb begin
        change    = bus.digit != prev_q;
        frame_dec = frame_q - 8'd1;
        phase_dec = phase_q - 8'd1;
        state_d   = state_q;
        visible_d = visible_q;
        frame_d   = frame_q;
        phase_d   = phase_q;
        if (change) begin
            state_d   = BLINK;
            frame_d   = FRAMES;
            phase_d   = PERIOD;
            visible_d = 1'b0;
        end else if (state_q == IDLE) begin
            visible_d = 1'b1;
        end else if (bus.startOfFrame) begin
            frame_d   = frame_dec;
            phase_d   = phase_dec == 8'd0 ? PERIOD : phase_dec;
            visible_d = phase_dec == 8'd0 ? ~visible_q : visible_q;
            if (frame_dec == 8'd0) begin
                state_d   = IDLE;
                visible_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetN_i) begin
            state_q   <= IDLE;
            visible_q <= 1'b1;
            frame_q   <= 8'd0;
            phase_q   <= 8'd0;
            prev_q    <= 4'd0;
            draw_q    <= 1'b0;
            rgb_q     <= TRANSPARENT_ENCODING;
        end else begin
            state_q   <= state_d;
            visible_q <= visible_d;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            prev_q    <= bus.digit;
            draw_q    <= draw_d;
            rgb_q     <= draw_d ? DIGIT_COLOR : TRANSPARENT_ENCODING;
        end
    end

    assign bus.drawingRequest = draw_q;
    assign bus.RGBout         = rgb_q;
endmodule

// File: tb/tb_score_digit_bitmap.sv
// tb_score_digit_bitmap: scoreboard bench for the score digit pixel stage and its blink sequencing.
module tb_score_digit_bitmap;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       dr;
        logic [7:0] rgb;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    score_digit_bitmap_if bus();

    score_digit_bitmap dut (
        .clk_i   (clk),
        .resetN_i(resetN),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] font [10][16] = '{
        '{8'h00,8'h00,8'h3C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h18,8'h38,8'h78,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h7E,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h3C,8'h66,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h60,8'h60,8'h66,8'h7E,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h3C,8'h66,8'h06,8'h06,8'h1C,8'h06,8'h06,8'h06,8'h06,8'h66,8'h3C,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hCC,8'hFE,8'h0C,8'h0C,8'h0C,8'h1E,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h7E,8'h60,8'h60,8'h60,8'h7C,8'h06,8'h06,8'h06,8'h06,8'h66,8'h3C,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h1C,8'h30,8'h60,8'h60,8'h7C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h7E,8'h66,8'h06,8'h06,8'h0C,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h3C,8'h66,8'h66,8'h66,8'h3C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00},
        '{8'h00,8'h00,8'h3C,8'h66,8'h66,8'h66,8'h66,8'h3E,8'h06,8'h06,8'h06,8'h0C,8'h38,8'h00,8'h00,8'h00}
    };

    function automatic logic exp_draw(int d, int x, int y, logic ins, logic vis);
        logic [7:0] r;
        if (!ins || d > 9 || x > 15 || y > 31 || !vis) return 1'b0;
        r = font[d][y / 2];
        return r[7 - x / 2];
    endfunction

    function automatic logic blink_vis(int k);
        return k >= 60 ? 1'b1 : logic'((k / 8) % 2);
    endfunction

    task automatic drive(int d, int x, int y, logic ins);
        bus.digit = 4'(d);
        bus.offsetX = 11'(x);
        bus.offsetY = 11'(y);
        bus.InsideRectangle = ins;
    endtask

    task automatic frames(int n);
        repeat (n) begin
            bus.startOfFrame = 1'b1;
            @(posedge clk); #1;
            bus.startOfFrame = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        drive(0, 4, 4, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.drawingRequest !== 1'b0 || bus.RGBout !== 8'hFF) begin
            failures++;
            $display("FAIL reset_outputs got dr=%b rgb=%h exp dr=0 rgb=ff", bus.drawingRequest, bus.RGBout);
        end
        resetN = 1'b1;
        e = '{exp_draw(0, 4, 4, 1'b1, 1'b1), 8'h5b};
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (bus.drawingRequest !== e.dr || bus.RGBout !== e.rgb) begin
            failures++;
            $display("FAIL reset_release_pixel got dr=%b rgb=%h exp dr=%b rgb=%h", bus.drawingRequest, bus.RGBout, e.dr, e.rgb);
        end
        checks++;
        if (logic'(dut.state_q) !== 1'b0 || dut.visible_q !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got state=%b vis=%b exp state=0 vis=1", dut.state_q, dut.visible_q);
        end
    endtask

    task automatic test_static();
        drive(1, 0, 0, 1'b1);
        @(posedge clk); #1;
        frames(60);
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 16; x++) begin
                drive(1, x, y, 1'b1);
                e.dr = exp_draw(1, x, y, 1'b1, 1'b1);
                e.rgb = e.dr ? 8'h5b : 8'hFF;
                sb.push_back(e);
                @(posedge clk); #1;
                e = sb.pop_front();
                checks++;
                if (bus.drawingRequest !== e.dr || bus.RGBout !== e.rgb) begin
                    failures++;
                    $display("FAIL static_sweep x=%0d y=%0d got dr=%b rgb=%h exp dr=%b rgb=%h", x, y, bus.drawingRequest, bus.RGBout, e.dr, e.rgb);
                end
            end
        end
    endtask

    task automatic test_blink();
        drive(2, 4, 4, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) frames(1);
            e.dr = exp_draw(2, 4, 4, 1'b1, blink_vis(k));
            e.rgb = e.dr ? 8'h5b : 8'hFF;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.drawingRequest !== e.dr || bus.RGBout !== e.rgb) begin
                failures++;
                $display("FAIL blink_frame k=%0d got dr=%b rgb=%h exp dr=%b rgb=%h", k, bus.drawingRequest, bus.RGBout, e.dr, e.rgb);
            end
        end
        checks++;
        if (logic'(dut.state_q) !== 1'b0 || dut.visible_q !== 1'b1) begin
            failures++;
            $display("FAIL blink_end got state=%b vis=%b exp state=0 vis=1", dut.state_q, dut.visible_q);
        end
    endtask

    task automatic test_restart();
        drive(5, 4, 12, 1'b1);
        @(posedge clk); #1;
        frames(20);
        checks++;
        if (dut.frame_q !== 8'd40 || dut.phase_q !== 8'd4 || dut.visible_q !== 1'b0) begin
            failures++;
            $display("FAIL restart_mid got frame=%0d phase=%0d vis=%b exp frame=40 phase=4 vis=0", dut.frame_q, dut.phase_q, dut.visible_q);
        end
        drive(6, 4, 12, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (dut.frame_q !== 8'd60 || dut.phase_q !== 8'd8 || dut.visible_q !== 1'b0) begin
            failures++;
            $display("FAIL restart_reload got frame=%0d phase=%0d vis=%b exp frame=60 phase=8 vis=0", dut.frame_q, dut.phase_q, dut.visible_q);
        end
        e = '{exp_draw(6, 4, 12, 1'b1, 1'b0), 8'hFF};
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (bus.drawingRequest !== e.dr || bus.RGBout !== e.rgb) begin
            failures++;
            $display("FAIL restart_hidden got dr=%b rgb=%h exp dr=%b rgb=%h", bus.drawingRequest, bus.RGBout, e.dr, e.rgb);
        end
        frames(3);
        drive(7, 4, 12, 1'b1);
        bus.startOfFrame = 1'b1;
        @(posedge clk); #1;
        bus.startOfFrame = 1'b0;
        checks++;
        if (dut.frame_q !== 8'd60 || dut.phase_q !== 8'd8 || dut.visible_q !== 1'b0) begin
            failures++;
            $display("FAIL restart_coincident got frame=%0d phase=%0d vis=%b exp frame=60 phase=8 vis=0", dut.frame_q, dut.phase_q, dut.visible_q);
        end
        frames(1);
        checks++;
        if (dut.frame_q !== 8'd59 || dut.phase_q !== 8'd7) begin
            failures++;
            $display("FAIL restart_first_dec got frame=%0d phase=%0d exp frame=59 phase=7", dut.frame_q, dut.phase_q);
        end
    endtask

    task automatic test_range();
        int px [7] = '{4, 16, 20, 4, 4, 15, 6};
        int py [7] = '{4, 4, 4, 32, 36, 31, 5};
        logic pin [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        resetN = 1'b0;
        drive(0, 0, 0, 1'b0);
        @(posedge clk); #1;
        resetN = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(0, px[i], py[i], pin[i]);
            e.dr = exp_draw(0, px[i], py[i], pin[i], 1'b1);
            e.rgb = e.dr ? 8'h5b : 8'hFF;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (bus.drawingRequest !== e.dr || bus.RGBout !== e.rgb) begin
                failures++;
                $display("FAIL range x=%0d y=%0d ins=%b got dr=%b rgb=%h exp dr=%b rgb=%h", px[i], py[i], pin[i], bus.drawingRequest, bus.RGBout, e.dr, e.rgb);
            end
        end
        drive(10, 0, 0, 1'b1);
        @(posedge clk); #1;
        frames(60);
        checks++;
        if (dut.visible_q !== 1'b1) begin
            failures++;
            $display("FAIL blank_visible got vis=%b exp vis=1", dut.visible_q);
        end
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 16; x++) begin
                drive(10, x, y, 1'b1);
                e = '{exp_draw(10, x, y, 1'b1, 1'b1), 8'hFF};
                sb.push_back(e);
                @(posedge clk); #1;
                e = sb.pop_front();
                checks++;
                if (bus.drawingRequest !== e.dr || bus.RGBout !== e.rgb) begin
                    failures++;
                    $display("FAIL blank_sweep x=%0d y=%0d got dr=%b rgb=%h exp dr=%b rgb=%h", x, y, bus.drawingRequest, bus.RGBout, e.dr, e.rgb);
                end
            end
        end
    endtask

    task automatic test_reset_mid_blink();
        drive(3, 4, 4, 1'b1);
        @(posedge clk); #1;
        frames(30);
        checks++;
        if (logic'(dut.state_q) !== 1'b1 || dut.frame_q !== 8'd30) begin
            failures++;
            $display("FAIL midblink_pre got state=%b frame=%0d exp state=1 frame=30", dut.state_q, dut.frame_q);
        end
        resetN = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (logic'(dut.state_q) !== 1'b0 || dut.visible_q !== 1'b1 || dut.frame_q !== 8'd0 || dut.phase_q !== 8'd0 || dut.prev_q !== 4'd0) begin
            failures++;
            $display("FAIL midblink_state got state=%b vis=%b frame=%0d phase=%0d prev=%0d exp 0/1/0/0/0", dut.state_q, dut.visible_q, dut.frame_q, dut.phase_q, dut.prev_q);
        end
        checks++;
        if (bus.drawingRequest !== 1'b0 || bus.RGBout !== 8'hFF) begin
            failures++;
            $display("FAIL midblink_outputs got dr=%b rgb=%h exp dr=0 rgb=ff", bus.drawingRequest, bus.RGBout);
        end
        resetN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.startOfFrame = 1'b0;
        drive(0, 0, 0, 1'b0);
        test_reset();
        test_static();
        test_blink();
        test_restart();
        test_range();
        test_reset_mid_blink();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
